// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem req/ack fetcher feeding decode via komut valid/ready (optional FETCH_PERF_EN counters)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] komut,
   output logic        komut_valid,
   input  logic        komut_ready,
   output logic [31:0] pc_out,
   input  logic        hata,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_cycles
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;
   state_t      state, state_n;
   logic [31:0] pc, pc_n, addr_n, komut_n, pc_out_n, tgt;
   logic        req_n, valid_n, halted_n, flush, flush_n, fire;
   assign tgt  = {branch_target[31:2], 2'b00};
   assign fire = komut_valid & komut_ready;
   // next-state and next-register values; halt beats redirect beats handshake
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      addr_n   = imem_addr;
      req_n    = imem_req;
      komut_n  = komut;
      pc_out_n = pc_out;
      valid_n  = komut_valid;
      halted_n = halted;
      flush_n  = flush;
      case (state)
         IDLE: begin
            if (branch_taken) pc_n = tgt;
            else begin
               addr_n  = pc;
               req_n   = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (branch_taken) begin
               pc_n = tgt;
               if (imem_ack) begin
                  req_n   = 1'b0;
                  flush_n = 1'b0;
                  state_n = IDLE;
               end else flush_n = 1'b1;
            end else if (imem_ack) begin
               req_n   = 1'b0;
               flush_n = 1'b0;
               if (flush) state_n = IDLE;
               else begin
                  komut_n  = imem_rdata;
                  pc_out_n = pc;
                  valid_n  = 1'b1;
                  pc_n     = pc + 32'(PC_STEP);
                  state_n  = HOLD;
               end
            end
         end
         HOLD: begin
            if (fire && hata) begin
               valid_n  = 1'b0;
               halted_n = 1'b1;
               state_n  = HALT;
            end else if (branch_taken) begin
               pc_n    = tgt;
               valid_n = 1'b0;
               state_n = IDLE;
            end else if (fire) begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         end
         default: ;
      endcase
   end
   // state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_addr   <= '0;
         imem_req    <= 1'b0;
         komut       <= '0;
         pc_out      <= '0;
         komut_valid <= 1'b0;
         halted      <= 1'b0;
         flush       <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         imem_addr   <= addr_n;
         imem_req    <= req_n;
         komut       <= komut_n;
         pc_out      <= pc_out_n;
         komut_valid <= valid_n;
         halted      <= halted_n;
         flush       <= flush_n;
      end
   end
`ifdef FETCH_PERF_EN
   // legal transfers and back-pressured cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count  <= '0;
         stall_cycles <= '0;
      end else begin
         fetch_count  <= fetch_count + 32'(fire & ~hata);
         stall_cycles <= stall_cycles + 32'(komut_valid & ~komut_ready);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table and sequence checks for fetch_unit
module tb_fetch_unit;
   logic        clk = 0, reset = 1, reset2 = 1, imem_ack = 0, ack2 = 0;
   logic        komut_ready = 0, hata = 0, branch_taken = 0;
   logic [31:0] imem_rdata = 0, branch_target = 0;
   logic        imem_req, komut_valid, halted, req2, valid2, halted2;
   logic [31:0] imem_addr, komut, pc_out, addr2, komut2, pc_out2;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, stall_cycles, fc2, sc2;
`endif
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .komut(komut),
      .komut_valid(komut_valid), .komut_ready(komut_ready), .pc_out(pc_out),
      .hata(hata), .branch_taken(branch_taken), .branch_target(branch_target),
      .halted(halted)
`ifdef FETCH_PERF_EN
      , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
   );
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
      .imem_ack(ack2), .imem_rdata(imem_rdata), .komut(komut2),
      .komut_valid(valid2), .komut_ready(komut_ready), .pc_out(pc_out2),
      .hata(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
      .halted(halted2)
`ifdef FETCH_PERF_EN
      , .fetch_count(fc2), .stall_cycles(sc2)
`endif
   );
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          stalls;
   } vec_t;
   vec_t vecs[5];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_req(input string n);
      int k = 0;
      while (!imem_req && k < 20) begin
         tick;
         k++;
      end
      chk(n, 32'(imem_req), 32'd1);
   endtask
   task automatic do_ack(input logic [31:0] d);
      imem_ack   = 1;
      imem_rdata = d;
      tick;
      imem_ack   = 0;
   endtask
   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int stalls);
`ifdef FETCH_PERF_EN
      logic [31:0] s0, f0;
`endif
      wait_req("req_seen");
      chk("imem_addr", imem_addr, a);
      do_ack(d);
      chk("valid_after_ack", 32'(komut_valid), 32'd1);
      chk("komut", komut, d);
      chk("pc_out", pc_out, a);
      chk("halted_low", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
      s0 = stall_cycles;
      f0 = fetch_count;
`endif
      for (int i = 0; i < stalls; i++) begin
         tick;
         chk("stall_komut", komut, d);
         chk("stall_pc_out", pc_out, a);
         chk("stall_valid", 32'(komut_valid), 32'd1);
         chk("stall_no_req", 32'(imem_req), 32'd0);
      end
`ifdef FETCH_PERF_EN
      chk("stall_cycles", stall_cycles - s0, 32'(stalls));
`endif
      komut_ready = 1;
      tick;
      komut_ready = 0;
      chk("valid_after_fire", 32'(komut_valid), 32'd0);
`ifdef FETCH_PERF_EN
      chk("fetch_count", fetch_count - f0, 32'd1);
`endif
   endtask
   initial begin
      vecs[0] = '{32'h0000_0000, 32'h1111_0001, 0};
      vecs[1] = '{32'h0000_0004, 32'h2222_0002, 0};
      vecs[2] = '{32'h0000_0008, 32'h3333_0003, 0};
      vecs[3] = '{32'h0000_000C, 32'h4444_0004, 5};
      vecs[4] = '{32'h0000_0010, 32'h5555_0005, 2};
      tick;
      tick;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_komut", komut, 32'd0);
      chk("rst_valid", 32'(komut_valid), 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      reset = 0;
      foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].data, vecs[i].stalls);
      // branch in REQ, ack arrives 3 cycles later and must be dropped
      wait_req("t3_req");
      chk("t3_addr", imem_addr, 32'h14);
      branch_taken  = 1;
      branch_target = 32'h0000_0103;
      tick;
      branch_taken  = 0;
      chk("t3_req_held", 32'(imem_req), 32'd1);
      chk("t3_addr_held", imem_addr, 32'h14);
      tick;
      chk("t3_no_valid1", 32'(komut_valid), 32'd0);
      tick;
      chk("t3_no_valid2", 32'(komut_valid), 32'd0);
      do_ack(32'hBAD0_0003);
      chk("t3_drop_valid", 32'(komut_valid), 32'd0);
      chk("t3_drop_req", 32'(imem_req), 32'd0);
      fetch(32'h0000_0100, 32'h6666_0006, 0);
      // branch coinciding with ack
      wait_req("t4_req");
      chk("t4_addr", imem_addr, 32'h104);
      imem_ack      = 1;
      imem_rdata    = 32'hBAD0_0004;
      branch_taken  = 1;
      branch_target = 32'h0000_0200;
      tick;
      imem_ack      = 0;
      branch_taken  = 0;
      chk("t4_drop_valid", 32'(komut_valid), 32'd0);
      chk("t4_drop_req", 32'(imem_req), 32'd0);
      fetch(32'h0000_0200, 32'h7777_0007, 0);
      // branch while an instruction is waiting in HOLD
      wait_req("hb_req");
      do_ack(32'h8888_0008);
      chk("hb_valid", 32'(komut_valid), 32'd1);
      branch_taken  = 1;
      branch_target = 32'h0000_0300;
      tick;
      branch_taken  = 0;
      chk("hb_killed", 32'(komut_valid), 32'd0);
      fetch(32'h0000_0300, 32'h9999_0009, 0);
      // illegal instruction halts permanently
      wait_req("t5_req");
      do_ack(32'hDEAD_BEEF);
      hata        = 1;
      komut_ready = 1;
      tick;
      hata        = 0;
      komut_ready = 0;
      chk("t5_halted", 32'(halted), 32'd1);
      chk("t5_valid", 32'(komut_valid), 32'd0);
      chk("t5_req", 32'(imem_req), 32'd0);
      for (int i = 0; i < 20; i++) begin
         branch_taken  = 1;
         branch_target = 32'h0000_0400;
         imem_ack      = i[0];
         komut_ready   = 1;
         tick;
         chk("t5_halt_req", 32'(imem_req), 32'd0);
      end
      branch_taken = 0;
      imem_ack     = 0;
      komut_ready  = 0;
      chk("t5_halted_sticky", 32'(halted), 32'd1);
      reset = 1;
      #1;
      chk("t5_rst_halted", 32'(halted), 32'd0);
      tick;
      reset = 0;
      wait_req("t5_restart");
      chk("t5_restart_addr", imem_addr, 32'h0);
      // PC wrap and asynchronous reset on the second instance
      reset2 = 0;
      tick;
      chk("t6_req", 32'(req2), 32'd1);
      chk("t6_addr0", addr2, 32'hFFFF_FFFC);
      ack2       = 1;
      imem_rdata = 32'hCAFE_0010;
      tick;
      ack2       = 0;
      chk("t6_valid", 32'(valid2), 32'd1);
      chk("t6_pc_out", pc_out2, 32'hFFFF_FFFC);
      chk("t6_komut", komut2, 32'hCAFE_0010);
      komut_ready = 1;
      tick;
      komut_ready = 0;
      tick;
      chk("t6_req2", 32'(req2), 32'd1);
      chk("t6_wrap_addr", addr2, 32'h0000_0000);
      #2;
      reset2 = 1;
      #1;
      chk("t6_arst_req", 32'(req2), 32'd0);
      chk("t6_arst_addr", addr2, 32'd0);
      chk("t6_arst_komut", komut2, 32'd0);
      chk("t6_arst_valid", 32'(valid2), 32'd0);
      chk("t6_arst_pc_out", pc_out2, 32'd0);
      chk("t6_arst_halted", 32'(halted2), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
